// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - shares one multi-cycle mul/div unit between two EX-stage ALU slots
// Fixed priority to slot 0 (older instruction); results held per slot until EX advances.
module muldiv_sched (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        ex_advance_i,
  input  logic [1:0]  req_start_i,
  input  logic [1:0]  req_sign_i,
  input  logic [1:0]  req_div_i,
  input  logic [31:0] req_a0_i,
  input  logic [31:0] req_b0_i,
  input  logic [31:0] req_a1_i,
  input  logic [31:0] req_b1_i,
  output logic [1:0]  resp_ready_o,
  output logic [63:0] resp_result0_o,
  output logic [63:0] resp_result1_o,
  output logic        unit_start_o,
  output logic        unit_sign_o,
  output logic        unit_div_o,
  output logic [31:0] unit_a_o,
  output logic [31:0] unit_b_o,
  output logic        unit_cancel_o,
  input  logic        unit_ready_i,
  input  logic [63:0] unit_result_i,
  output logic        busy_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        sign_q, sign_d;
  logic        div_q, div_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [63:0] rres0_q, rres0_d;
  logic [63:0] rres1_q, rres1_d;
  logic [1:0]  eligible;

  assign eligible = req_start_i & ~rvalid_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    sign_d   = sign_q;
    div_d    = div_q;
    a_d      = a_q;
    b_d      = b_q;
    rres0_d  = rres0_q;
    rres1_d  = rres1_q;
    // A completing result is OR-ed in after the advance clear, so it survives it
    rvalid_d = ex_advance_i ? 2'b00 : rvalid_q;

    if (flush_i) begin
      state_d  = IDLE;
      rvalid_d = 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (eligible[0]) begin
            state_d = BUSY;
            owner_d = 1'b0;
            sign_d  = req_sign_i[0];
            div_d   = req_div_i[0];
            a_d     = req_a0_i;
            b_d     = req_b0_i;
          end else if (eligible[1]) begin
            state_d = BUSY;
            owner_d = 1'b1;
            sign_d  = req_sign_i[1];
            div_d   = req_div_i[1];
            a_d     = req_a1_i;
            b_d     = req_b1_i;
          end
        end
        BUSY: begin
          if (unit_ready_i) begin
            state_d = IDLE;
            if (owner_q) begin
              rres1_d     = unit_result_i;
              rvalid_d[1] = 1'b1;
            end else begin
              rres0_d     = unit_result_i;
              rvalid_d[0] = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      sign_q   <= 1'b0;
      div_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rvalid_q <= 2'b00;
      rres0_q  <= '0;
      rres1_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      sign_q   <= sign_d;
      div_q    <= div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rvalid_q <= rvalid_d;
      rres0_q  <= rres0_d;
      rres1_q  <= rres1_d;
    end
  end

  assign busy_o         = (state_q == BUSY);
  assign unit_start_o   = (state_q == BUSY);
  assign unit_sign_o    = sign_q;
  assign unit_div_o     = div_q;
  assign unit_a_o       = a_q;
  assign unit_b_o       = b_q;
  // Cancel must hit the unit in the flush cycle itself so it drops any same-cycle result
  assign unit_cancel_o  = (state_q == BUSY) && flush_i;
  assign resp_ready_o   = rvalid_q;
  assign resp_result0_o = rres0_q;
  assign resp_result1_o = rres1_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - directed self-checking bench for muldiv_sched
// Includes a small mul/div unit model answering after a fixed number of BUSY cycles.
module tb_muldiv_sched;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, ex_advance;
  logic [1:0]  req_start, req_sign, req_div;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  resp_ready;
  logic [63:0] resp_result0, resp_result1;
  logic        unit_start, unit_sign, unit_div, unit_cancel, unit_ready;
  logic [31:0] unit_a, unit_b;
  logic [63:0] unit_result;
  logic        busy;
  logic        force_ready;

  int n_cmp = 0;
  int n_err = 0;
  int cancel_cnt = 0;
  int mdl_cnt;

  always #5 clk = ~clk;

  muldiv_sched dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_advance_i(ex_advance),
    .req_start_i(req_start), .req_sign_i(req_sign), .req_div_i(req_div),
    .req_a0_i(req_a0), .req_b0_i(req_b0), .req_a1_i(req_a1), .req_b1_i(req_b1),
    .resp_ready_o(resp_ready), .resp_result0_o(resp_result0), .resp_result1_o(resp_result1),
    .unit_start_o(unit_start), .unit_sign_o(unit_sign), .unit_div_o(unit_div),
    .unit_a_o(unit_a), .unit_b_o(unit_b), .unit_cancel_o(unit_cancel),
    .unit_ready_i(unit_ready), .unit_result_i(unit_result), .busy_o(busy)
  );

  // Unit model
  logic [31:0] mq, mr;
  logic [63:0] mp;
  always_comb begin
    mq = '1;
    mr = unit_a;
    if (unit_b != 32'd0) begin
      if (unit_sign) begin
        mq = $signed(unit_a) / $signed(unit_b);
        mr = $signed(unit_a) % $signed(unit_b);
      end else begin
        mq = unit_a / unit_b;
        mr = unit_a % unit_b;
      end
    end
    if (unit_sign) mp = $signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b});
    else           mp = {32'd0, unit_a} * {32'd0, unit_b};
  end
  assign unit_result = unit_div ? {mr, mq} : mp;
  assign unit_ready  = (unit_start && mdl_cnt == LAT - 1) || force_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) mdl_cnt <= 0;
    else if (unit_start && !unit_cancel && !unit_ready) mdl_cnt <= mdl_cnt + 1;
    else mdl_cnt <= 0;
  end

  always @(posedge clk) if (unit_cancel) cancel_cnt <= cancel_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ready(input logic [1:0] mask, input string tag);
    int n = 0;
    while ((resp_ready & mask) != mask && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_unit_ready(input string tag);
    int n = 0;
    while (!unit_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic release_results();
    req_start  = 2'b00;
    ex_advance = 1'b1;
    step();
    ex_advance = 1'b0;
  endtask

  initial begin
    int starts, grants, unstable, lost, c0, n;
    rst = 1'b1; flush = 0; ex_advance = 0; force_ready = 0;
    req_start = 0; req_sign = 0; req_div = 0;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    repeat (2) step();
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_start", {63'd0, unit_start}, 64'd0);
    check_eq("rst_ready", {62'd0, resp_ready}, 64'd0);
    check_eq("rst_res0", resp_result0, 64'd0);
    check_eq("rst_unit_a", {32'd0, unit_a}, 64'd0);
    rst = 1'b0;
    step();

    // Single signed mul on slot 0
    req_start = 2'b01; req_sign = 2'b01; req_div = 2'b00;
    req_a0 = 32'hFFFF_FFFE; req_b0 = 32'd3;
    step();
    check_eq("mul_unit_a", {32'd0, unit_a}, 64'hFFFF_FFFE);
    starts = 0; n = 0;
    while (unit_start && n < 20) begin
      starts++;
      if (n == 1) begin
        req_b0 = 32'd5;
        #1 check_eq("mul_operand_latched", {32'd0, unit_b}, 64'd3);
      end
      step();
      n++;
    end
    check_eq("mul_start_cycles", starts, 64'd3);
    check_eq("mul_ready", {62'd0, resp_ready}, 64'd1);
    check_eq("mul_result", resp_result0, 64'hFFFF_FFFF_FFFF_FFFA);

    // Hold under stall with request still present
    grants = 0; unstable = 0; lost = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (unit_start) grants++;
      if (resp_result0 != 64'hFFFF_FFFF_FFFF_FFFA) unstable++;
      if (resp_ready != 2'b01) lost++;
    end
    check_eq("stall_regrant", grants, 64'd0);
    check_eq("stall_stable", unstable, 64'd0);
    check_eq("stall_ready", lost, 64'd0);
    release_results();
    check_eq("advance_clear", {62'd0, resp_ready}, 64'd0);

    // Contention: slot 0 DIVU 100/7, slot 1 DIV -7/2
    req_start = 2'b11; req_div = 2'b11; req_sign = 2'b10;
    req_a0 = 32'd100; req_b0 = 32'd7; req_a1 = 32'hFFFF_FFF9; req_b1 = 32'd2;
    step();
    check_eq("cont_first_a", {32'd0, unit_a}, 64'd100);
    wait_ready(2'b01, "cont_slot0");
    check_eq("cont_bubble", {63'd0, busy}, 64'd0);
    check_eq("cont_res0", resp_result0, 64'h0000_0002_0000_000E);
    step();
    check_eq("cont_second_busy", {63'd0, busy}, 64'd1);
    check_eq("cont_second_a", {32'd0, unit_a}, 64'hFFFF_FFF9);
    wait_ready(2'b11, "cont_slot1");
    check_eq("cont_ready_both", {62'd0, resp_ready}, 64'd3);
    check_eq("cont_res1", resp_result1, 64'hFFFF_FFFF_FFFF_FFFD);
    check_eq("cont_res0_held", resp_result0, 64'h0000_0002_0000_000E);
    release_results();
    check_eq("cont_clear", {62'd0, resp_ready}, 64'd0);

    // Flush in the 2nd BUSY cycle of a divide
    c0 = cancel_cnt;
    req_start = 2'b01; req_div = 2'b01; req_sign = 2'b00;
    req_a0 = 32'd50; req_b0 = 32'd5;
    step();
    step();
    flush = 1'b1; req_start = 2'b00;
    #1 check_eq("flush_cancel", {63'd0, unit_cancel}, 64'd1);
    step();
    flush = 1'b0;
    #1;
    check_eq("flush_idle", {63'd0, busy}, 64'd0);
    check_eq("flush_cancel_off", {63'd0, unit_cancel}, 64'd0);
    check_eq("flush_cancel_count", cancel_cnt - c0, 64'd1);
    check_eq("flush_ready", {62'd0, resp_ready}, 64'd0);
    force_ready = 1'b1;
    step();
    force_ready = 1'b0;
    check_eq("late_ready_ignored", {62'd0, resp_ready}, 64'd0);
    check_eq("late_ready_idle", {63'd0, busy}, 64'd0);

    // Flush coincident with unit_ready
    req_start = 2'b01; req_div = 2'b00; req_sign = 2'b00;
    req_a0 = 32'd6; req_b0 = 32'd7;
    step();
    wait_unit_ready("coinc");
    flush = 1'b1; req_start = 2'b00;
    step();
    flush = 1'b0;
    check_eq("coinc_idle", {63'd0, busy}, 64'd0);
    check_eq("coinc_ready", {62'd0, resp_ready}, 64'd0);

    // ex_advance together with unit_ready: old bit cleared, new bit kept
    req_start = 2'b01;
    step();
    wait_ready(2'b01, "adv_slot0");
    check_eq("adv_res0", resp_result0, 64'd42);
    req_start = 2'b11; req_a1 = 32'd3; req_b1 = 32'd4;
    step();
    check_eq("adv_slot1_a", {32'd0, unit_a}, 64'd3);
    wait_unit_ready("adv_unit");
    ex_advance = 1'b1;
    step();
    ex_advance = 1'b0;
    check_eq("adv_ready", {62'd0, resp_ready}, 64'd2);
    check_eq("adv_res1", resp_result1, 64'd12);
    release_results();

    // Asynchronous reset while BUSY
    req_start = 2'b01; req_sign = 2'b01; req_div = 2'b00;
    req_a0 = 32'hFFFF_FFFD; req_b0 = 32'hFFFF_FFFC;
    step();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_start", {63'd0, unit_start}, 64'd0);
    check_eq("arst_unit_a", {32'd0, unit_a}, 64'd0);
    check_eq("arst_res0", resp_result0, 64'd0);
    check_eq("arst_res1", resp_result1, 64'd0);
    step();
    rst = 1'b0;
    step();
    wait_ready(2'b01, "post_rst");
    check_eq("post_rst_res0", resp_result0, 64'd12);
    release_results();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
